variable_br_wrapper: RTL and testbench
======================================

VARIABLE_BR_WRAPPER -- requirements
Module: variable_br_wrapper

Interface
REQ-001 Parameter CLK_HZ, default 100000000, SHALL be the system clock frequency in Hz used to derive baud divisors.
REQ-002 clk  input  1  SHALL be the single system clock; all logic on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Rx  input  1  SHALL be the serial receive line, idle high.
REQ-005 Enable  input  1  SHALL be the transmit request; a one-cycle high pulse starts a frame.
REQ-006 BR_Select  input  3  SHALL select the baud rate.
REQ-007 Tx_Data  input  8  SHALL be the byte to transmit.
REQ-008 Tx  output  1  SHALL be the serial transmit line, idle high.
REQ-009 Rx_Data  output  8  SHALL hold the last correctly framed received byte.
REQ-010 BR_Clocks  output  15  SHALL be the live divisor (clocks per bit) decoded from BR_Select.
REQ-011 Tx_r_BR_Clocks  output  15  SHALL be the divisor latched by the transmitter at frame start.
REQ-012 Rx_r_BR_Clocks  output  15  SHALL be the divisor latched by the receiver at start-bit detection.
REQ-013 clk_count  output  15  SHALL be the transmitter's bit-period clock counter.

Function
REQ-014 BR_Select SHALL decode combinationally: 000=9600, 001=19200, 010=38400, 011=57600, 100=115200, 101=230400, 110=460800, 111=921600 baud; BR_Clocks = CLK_HZ/baud, truncated to 15 bits (10416 for 000 at default CLK_HZ).
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 Transmitter states SHALL be IDLE, START, DATA, STOP; IDLE drives Tx=1.
REQ-017 Enable high in IDLE SHALL, on that edge, latch Tx_Data and BR_Clocks into Tx_r_BR_Clocks and enter START; Tx goes low in the following cycle.
REQ-018 Enable while the transmitter is not in IDLE SHALL be ignored; no queuing.
REQ-019 Each bit SHALL last exactly Tx_r_BR_Clocks clocks; clk_count counts 0..Tx_r_BR_Clocks-1 and wraps to 0 on each bit boundary.
REQ-020 After the stop bit the transmitter SHALL return to IDLE; clk_count SHALL be 0 in IDLE.
REQ-021 BR_Select changes mid-frame SHALL NOT affect an in-progress Tx or Rx frame.
REQ-022 Receiver states SHALL be IDLE, START, DATA, STOP; a falling Rx in IDLE latches BR_Clocks into Rx_r_BR_Clocks and enters START.
REQ-023 In START the receiver SHALL wait Rx_r_BR_Clocks/2 clocks and re-sample; Rx high returns to IDLE (glitch), low enters DATA.
REQ-024 DATA bits SHALL be sampled every Rx_r_BR_Clocks clocks thereafter (mid-bit), shifted LSB first.
REQ-025 Rx_Data SHALL update only if the stop-bit sample is 1; a 0 stop bit discards the byte; either way the receiver returns to IDLE and waits for Rx high before a new start.
REQ-026 Rx held permanently low SHALL never update Rx_Data.

Reset
REQ-027 rst_n low SHALL force: Tx=1, Rx_Data=0, Tx_r_BR_Clocks=0, Rx_r_BR_Clocks=0, clk_count=0, both state machines IDLE, shift registers 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no partial byte is delivered.

Configuration
REQ-029 With RX_SYNC_EN defined, Rx SHALL pass through a two-flop synchronizer (reset value 1) before the receiver, adding 2 cycles of detection latency; without it Rx feeds the receiver directly.

Structure
REQ-030 Package variable_br_pkg SHALL hold the eight baud constants, the divisor function, and the Tx/Rx state enum typedefs.
REQ-031 The receiver SHALL be the sub-module uart_rx_core; transmitter and decode reside in the wrapper.

Verification
REQ-032 Reset, BR_Select=000 -> BR_Clocks=10416, Tx=1, clk_count=0, Rx_Data=0.
REQ-033 BR_Select=100, Tx_Data=8'hAA, Enable 1-cycle pulse -> Tx_r_BR_Clocks=868, Tx low 868 clocks, then 0,1,0,1,0,1,0,1 each 868 clocks, stop high, IDLE after 8680 clocks.
REQ-034 Second Enable pulse 100 clocks into the REQ-033 frame -> ignored; frame and timing unchanged.
REQ-035 Loop Tx to Rx, BR_Select=111, Tx_Data=8'h5A -> Rx_Data=8'h5A, Rx_r_BR_Clocks=108.
REQ-036 Rx held 0 from reset -> Rx_Data stays 8'h00 indefinitely.
REQ-037 rst_n pulsed low mid-frame -> Tx=1 and clk_count=0 immediately, next Enable starts a clean frame.

Source files
------------

// File: rtl/variable_br_pkg.sv
// variable_br_pkg: baud constants, divisor helper and UART state encodings
package variable_br_pkg;
  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_38400  = 38400;
  localparam int BAUD_57600  = 57600;
  localparam int BAUD_115200 = 115200;
  localparam int BAUD_230400 = 230400;
  localparam int BAUD_460800 = 460800;
  localparam int BAUD_921600 = 921600;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic logic [14:0] br_div(input int clk_hz, input logic [2:0] sel);
    int baud;
    baud = sel == 3'd0 ? BAUD_9600 :
           sel == 3'd1 ? BAUD_19200 :
           sel == 3'd2 ? BAUD_38400 :
           sel == 3'd3 ? BAUD_57600 :
           sel == 3'd4 ? BAUD_115200 :
           sel == 3'd5 ? BAUD_230400 :
           sel == 3'd6 ? BAUD_460800 : BAUD_921600;
    return 15'(clk_hz / baud);
  endfunction
endpackage

// File: rtl/variable_br_wrapper_if.sv
// variable_br_wrapper_if: serial pins, transmit request and divisor observation signals
interface variable_br_wrapper_if;
  logic Rx, Enable, Tx;
  logic [2:0] BR_Select;
  logic [7:0] Tx_Data, Rx_Data;
  logic [14:0] BR_Clocks, Tx_r_BR_Clocks, Rx_r_BR_Clocks, clk_count;
  modport master (output Rx, Enable, BR_Select, Tx_Data,
                  input Tx, Rx_Data, BR_Clocks, Tx_r_BR_Clocks, Rx_r_BR_Clocks, clk_count);
  modport slave (input Rx, Enable, BR_Select, Tx_Data,
                 output Tx, Rx_Data, BR_Clocks, Tx_r_BR_Clocks, Rx_r_BR_Clocks, clk_count);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver, mid-bit sampling with the divisor frozen at start-bit detection
import variable_br_pkg::*;
module uart_rx_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  input  logic [14:0] i_br_clocks,
  output logic [7:0]  o_rx_data,
  output logic [14:0] o_br_clocks
);
  rx_state_t r_state, w_next;
  logic [14:0] r_cnt, r_brc;
  logic [7:0] r_shift, r_data;
  logic [2:0] r_bit;
  logic r_prev, w_fall, w_sample;
  // edge detect means a line stuck low after a bad frame never restarts reception
  assign w_fall = r_prev & ~i_rx;
  assign o_rx_data = r_data;
  assign o_br_clocks = r_brc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt <= '0;
      r_brc <= '0;
      r_shift <= '0;
      r_bit <= '0;
      r_data <= '0;
      r_prev <= 1'b1;
    end else begin
      r_state <= w_next;
      r_prev <= i_rx;
      r_cnt <= (r_state == RX_IDLE || w_sample) ? '0 : r_cnt + 15'd1;
      if (r_state == RX_IDLE && w_fall) r_brc <= i_br_clocks;
      if (r_state == RX_DATA && w_sample) begin
        r_shift <= {i_rx, r_shift[7:1]};
        r_bit <= r_bit + 3'd1;
      end
      if (r_state == RX_STOP && w_sample && i_rx) r_data <= r_shift;
    end
  always_comb
    w_next = r_state == RX_IDLE ? (w_fall ? RX_START : RX_IDLE) :
             !w_sample ? r_state :
             r_state == RX_START ? (i_rx ? RX_IDLE : RX_DATA) :
             r_state == RX_DATA ? (r_bit == 3'd7 ? RX_STOP : RX_DATA) : RX_IDLE;
  always_comb
    w_sample = r_state == RX_START ? r_cnt == (r_brc >> 1) - 15'd1 :
               r_state != RX_IDLE && r_cnt == r_brc - 15'd1;
endmodule

// File: rtl/variable_br_wrapper.sv
// variable_br_wrapper: baud decode, 8N1 transmitter and uart_rx_core receiver.
// Define RX_SYNC_EN to insert a two-flop synchronizer on Rx.
import variable_br_pkg::*;
module variable_br_wrapper #(parameter int CLK_HZ = 100000000) (
  input logic clk,
  input logic rst_n,
  variable_br_wrapper_if.slave bus
);
  tx_state_t r_state, w_next;
  logic [14:0] r_cnt, r_brc;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic w_bit_end, w_rx;
  assign bus.BR_Clocks = br_div(CLK_HZ, bus.BR_Select);
  assign bus.Tx_r_BR_Clocks = r_brc;
  assign bus.clk_count = r_cnt;
  assign w_bit_end = r_cnt == r_brc - 15'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_cnt <= '0;
      r_brc <= '0;
      r_shift <= '0;
      r_bit <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == TX_IDLE || w_bit_end) ? '0 : r_cnt + 15'd1;
      if (r_state == TX_IDLE && bus.Enable) begin
        r_shift <= bus.Tx_Data;
        r_brc <= bus.BR_Clocks;
      end else if (r_state == TX_DATA && w_bit_end) r_shift <= r_shift >> 1;
      if (r_state == TX_DATA && w_bit_end) r_bit <= r_bit + 3'd1;
    end
  always_comb
    w_next = r_state == TX_IDLE ? (bus.Enable ? TX_START : TX_IDLE) :
             !w_bit_end ? r_state :
             r_state == TX_START ? TX_DATA :
             r_state == TX_DATA ? (r_bit == 3'd7 ? TX_STOP : TX_DATA) : TX_IDLE;
  always_comb
    bus.Tx = r_state == TX_START ? 1'b0 : r_state == TX_DATA ? r_shift[0] : 1'b1;
`ifdef RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], bus.Rx};
  assign w_rx = r_sync[1];
`else
  assign w_rx = bus.Rx;
`endif
  uart_rx_core u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .i_rx(w_rx),
    .i_br_clocks(bus.BR_Clocks),
    .o_rx_data(bus.Rx_Data),
    .o_br_clocks(bus.Rx_r_BR_Clocks)
  );
endmodule

// File: tb/tb_variable_br_wrapper.sv
// tb_variable_br_wrapper: directed UART checks with bit/byte scoreboards
module tb_variable_br_wrapper;
  logic clk = 1'b0, rst_n = 1'b0, loop = 1'b0, rx_drv = 1'b1;
  int total = 0, passed = 0, failed = 0;
  logic [31:0] sb[$];
  logic [7:0] rxq[$];
  int div_tab[8] = '{10416, 5208, 2604, 1736, 868, 434, 217, 108};
  variable_br_wrapper_if bus();
  variable_br_wrapper dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.Rx = loop ? bus.Tx : rx_drv;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Frame cycle j=0 is sampled just after the edge that accepts Enable
  task automatic tx_frame(input logic [7:0] d, input int n, input int dup_at);
    for (int b = 0; b < 10; b++) begin
      logic v;
      v = b == 0 ? 1'b0 : b == 9 ? 1'b1 : d[b-1];
      sb.push_back({31'd0, v});
      sb.push_back({31'd0, v});
    end
    bus.Tx_Data = d;
    bus.Enable = 1'b1;
    tick();
    chk("tx_r_brc_start", bus.Tx_r_BR_Clocks, n);
    for (int j = 0; j <= 10 * n; j++) begin
      if (j == dup_at) begin
        bus.Enable = 1'b1;
        bus.BR_Select = 3'b000;
      end else bus.Enable = 1'b0;
      if (j == 10 * n) begin
        chk("tx_idle", bus.Tx, 1);
        chk("clk_count_idle", bus.clk_count, 0);
      end else if (j % n == 0 || j % n == n - 1) begin
        chk("tx_bit", bus.Tx, sb.pop_front());
        if (j % n == n - 1) chk("clk_count_wrap", bus.clk_count, n - 1);
      end
      if (j < 10 * n) tick();
    end
    chk("tx_r_brc_end", bus.Tx_r_BR_Clocks, n);
    chk("sb_drain", sb.size(), 0);
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic stop, input int n, input logic chg);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[b];
      tick(n);
      if (chg && b == 0) bus.BR_Select = 3'b000;
    end
    rx_drv = 1'b1;
    tick(3 * n);
  endtask
  initial begin
    bus.Enable = 1'b0;
    bus.BR_Select = 3'b000;
    bus.Tx_Data = 8'h00;
    tick(3);
    chk("rst_br_clocks", bus.BR_Clocks, 10416);
    chk("rst_tx", bus.Tx, 1);
    chk("rst_clk_count", bus.clk_count, 0);
    chk("rst_rx_data", bus.Rx_Data, 0);
    chk("rst_tx_r_brc", bus.Tx_r_BR_Clocks, 0);
    chk("rst_rx_r_brc", bus.Rx_r_BR_Clocks, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_tx", bus.Tx, 1);
    for (int s = 0; s < 8; s++) begin
      bus.BR_Select = 3'(s);
      #1;
      chk("br_decode", bus.BR_Clocks, div_tab[s]);
    end
    // Rx stuck low from reset
    bus.BR_Select = 3'b111;
    rx_drv = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2500);
    chk("rx_stuck_low", bus.Rx_Data, 0);
    rx_drv = 1'b1;
    tick(300);
    chk("rx_stuck_low_after", bus.Rx_Data, 0);
    // AA at 115200 with ignored second Enable and mid-frame BR change
    bus.BR_Select = 3'b100;
    tick();
    tx_frame(8'hAA, 868, 100);
    // Loopback 5A at 921600
    bus.BR_Select = 3'b111;
    loop = 1'b1;
    tick(5);
    rxq.push_back(8'h5A);
    tx_frame(8'h5A, 108, -1);
    tick(20);
    chk("loop_rx_data", bus.Rx_Data, rxq.pop_front());
    chk("loop_rx_r_brc", bus.Rx_r_BR_Clocks, 108);
    loop = 1'b0;
    tick(20);
    // Bad stop bit discards, good frame with mid-frame BR change lands
    rxq.push_back(8'h5A);
    rx_frame(8'hC6, 1'b0, 108, 1'b0);
    chk("rx_bad_stop", bus.Rx_Data, rxq.pop_front());
    rxq.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1, 108, 1'b1);
    chk("rx_br_change", bus.Rx_Data, rxq.pop_front());
    chk("rx_r_brc_held", bus.Rx_r_BR_Clocks, 108);
    bus.BR_Select = 3'b111;
    rx_drv = 1'b0;
    tick(10);
    rx_drv = 1'b1;
    tick(300);
    chk("rx_glitch", bus.Rx_Data, 8'h3C);
    rxq.push_back(8'hC3);
    rx_frame(8'hC3, 1'b1, 108, 1'b0);
    chk("rx_after_glitch", bus.Rx_Data, rxq.pop_front());
    // Reset mid-frame
    bus.BR_Select = 3'b100;
    bus.Tx_Data = 8'hFF;
    bus.Enable = 1'b1;
    tick();
    bus.Enable = 1'b0;
    tick(2000);
    chk("mid_clk_count", bus.clk_count, 2000 % 868);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", bus.Tx, 1);
    chk("abort_clk_count", bus.clk_count, 0);
    chk("abort_tx_r_brc", bus.Tx_r_BR_Clocks, 0);
    chk("abort_rx_data", bus.Rx_Data, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    tx_frame(8'h81, 868, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
